// File: rtl/mem_host_master_pkg.sv
// mem_host_master_pkg: MemPortIo request encodings and the master FSM state type.
package mem_host_master_pkg;
    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;
    localparam logic [2:0] MT_B = 3'd0;
    localparam logic [2:0] MT_H = 3'd1;
    localparam logic [2:0] MT_WORD = 3'd3;
    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_RD_OUT, ST_DONE} state_e;
endpackage

// File: rtl/mem_host_master.sv
// mem_host_master: host-side MemPortIo initiator for word-aligned single and burst reads/writes
module mem_host_master
  import mem_host_master_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 8,
  parameter int TO_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic [DW-1:0] rdata,
  output logic          done,
  output logic          busy,
  output logic          err,
  output logic          mem_req_valid,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_data,
  output logic          mem_req_fcn,
  output logic [2:0]    mem_req_typ,
  input  logic          mem_req_ready,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_data
);
  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] WR = ST_WR;
  localparam logic [2:0] RD = ST_RD;
  localparam logic [2:0] RD_OUT = ST_RD_OUT;
  localparam logic [2:0] DONE = ST_DONE;
  logic [2:0] state, state_nx;
  logic [AW-1:0] addr;
  logic [LW-1:0] cnt;
  logic wr_hit, rd_hit, out_hit, last, timeout;
  assign wr_hit = state == WR && wdata_valid && mem_req_ready;
  assign rd_hit = state == RD && mem_req_ready && mem_resp_valid;
  assign out_hit = state == RD_OUT && rdata_ready;
  assign last = cnt == '0;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign wdata_ready = state == WR && mem_req_ready;
  assign rdata_valid = state == RD_OUT;
  assign mem_req_valid = (state == WR && wdata_valid) || state == RD;
  assign mem_req_addr = addr;
  assign mem_req_data = state == WR ? wdata : '0;
  assign mem_req_fcn = state == WR ? M_XWR : M_XRD;
  assign mem_req_typ = MT_WORD;
  always_comb
    state_nx = state == IDLE ? (cmd_valid ? (cmd_write ? WR : RD) : IDLE) :
               timeout ? DONE :
               state == WR ? (wr_hit && last ? DONE : WR) :
               state == RD ? (rd_hit ? RD_OUT : RD) :
               state == RD_OUT ? (out_hit ? (last ? DONE : RD) : RD_OUT) : IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        addr <= cmd_addr & ~AW'(3);
        cnt <= cmd_len;
      end else if (wr_hit || out_hit) begin
        addr <= addr + AW'(4);
        cnt <= cnt - 1'b1;
      end
      if (rd_hit)
        rdata <= mem_resp_data;
    end
  end
`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic stall;
  assign stall = mem_req_valid && !(wr_hit || rd_hit);
  assign timeout = stall && &to_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err <= 1'b0;
    end else begin
      to_cnt <= (wr_hit || rd_hit || timeout || state == IDLE) ? '0 : stall ? to_cnt + 1'b1 : to_cnt;
      err <= err | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: doc/mem_host_master.md
Name: mem_host_master

Overview:
- Host-side initiator on a MemPortIo link; issues word-aligned single and burst read/write requests to the scratchpad memory.
- Replaces direct testbench access for program load, memory dump and debug peeking via the host-target path.
- Accepts a command, streams write data in or read data out over valid/ready channels, and pulses done at burst end.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte lanes SW = DW/8.
- LW, 8, burst-length field width; beats = cmd_len + 1, so 1..256 at default.
- TO_W, 8, timeout counter width; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start byte address; bits [1:0] ignored and forced 0
- cmd_len  in  LW  beats minus one
- wdata_valid  in  1  write beat offered
- wdata_ready  out  1  write beat accepted
- wdata  in  DW  write beat data
- rdata_valid  out  1  read beat available
- rdata_ready  in  1  host consumes read beat
- rdata  out  DW  read beat data
- done  out  1  one-cycle pulse after last beat
- busy  out  1  high from command accept until done
- err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; tied 0 otherwise)
- mem  MemPortIo  initiator side: drives req.valid, req.addr, req.data, req.fcn, req.typ; samples req.ready, resp.valid, resp.data

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n.
- Outputs after reset: cmd_ready=1, all other outputs 0; req.valid=0, req.fcn=0, req.typ=MT_WORD, req.addr=0, req.data=0; state IDLE.
- Every request is a full word: req.typ=MT_WORD; fcn uses M_XWR=1 for writes, M_XRD=0 for reads.
- States: IDLE, WR, RD, RD_OUT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr (with [1:0]=0), remaining count=cmd_len and direction.
  - Go to WR or RD; busy rises the next cycle.
- WR:
  - wdata_ready = mem.req.ready.
  - req.valid = wdata_valid, with req.data=wdata and req.addr=current address.
  - A beat completes when wdata_valid & req.ready: address += 4, count -= 1.
  - When count was 0 at completion, go to DONE.
  - No beat is issued without wdata_valid; gaps are allowed.
- RD:
  - req.valid=1, addr held stable.
  - Beat completes when req.ready & resp.valid in the same cycle: register resp.data into rdata, then go to RD_OUT.
  - This is zero-wait for asynchronous memory, so latency is 1 cycle from request to rdata_valid.
- RD_OUT:
  - rdata_valid=1 and rdata stable until rdata_ready.
  - On handshake: address += 4, count -= 1; go to RD, or to DONE if count was 0.
  - req.valid=0 here, so no prefetch.
- DONE:
  - done=1 for exactly one cycle, busy=0 on exit.
  - Return to IDLE; the next command is accepted no earlier than the following cycle.
- Address arithmetic is modulo 2^AW; a burst crossing the top wraps to 0 silently.
- cmd_valid while busy: ignored, because cmd_ready=0.
- wdata_valid in IDLE or read states: ignored, because wdata_ready=0.
- Reset asserted mid-burst: immediate return to reset values; the partial burst is abandoned and no done is generated.
- Writes already accepted by memory remain.

Optional Feature:
- MEM_TIMEOUT_EN
- Defined:
  - A TO_W counter runs while req.valid=1 and the beat has not completed.
  - It clears on each completed beat.
  - At all-ones: abandon the burst, set err (sticky until reset), go to DONE so done still pulses.
- Undefined: no counter; err tied 0; the master waits indefinitely.

Decomposition:
- Shared package holds:
  - mem fcn constants M_XRD=0, M_XWR=1;
  - typ constants MT_B=0, MT_H=1, MT_WORD=3 (typ = bytes-1, width 3);
  - state enum typedef.
- A sub-module is not natural; a single module suffices.
- The timeout counter is an inline generate under the macro.

Test Plan:
- Single write: cmd_write=1, addr=0x100, len=0, wdata=0xDEADBEEF.
  - One req with fcn=1, typ=3, addr=0x100, then done pulse.
  - Memory word 0x40 = 0xDEADBEEF.
- Burst write then read: write 4 beats at 0x200 with 0x11,0x22,0x33,0x44; read len=3 at 0x200.
  - rdata sequence 0x11,0x22,0x33,0x44, each rdata_valid 1 cycle after its request.
  - Single done per burst.
- Backpressure: read len=1 with rdata_ready held 0 for 5 cycles.
  - rdata stable, req.valid=0 during stall, second address 0x204 issued only after handshake.
- Unaligned/wrap: addr=0xFFFFFFFE, len=1, write.
  - Requests at 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: assert rst_n=0 after 2 of 8 write beats.
  - All outputs at reset values immediately, no done.
  - New command accepted after release.
- With MEM_TIMEOUT_EN, TO_W=4: hold req.ready=0.
  - After 15 cycles err=1 and done pulses; err stays 1 through a following good command.
